// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: one DATA_W-bit adder shared round-robin by NREQ requesters, registered id-tagged result.
// Defining ADDER_ARB_OVF_EN adds the registered signed-overflow output res_ovf.
module adder_share_arbiter #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*DATA_W-1:0]   req_a,
   input  logic [NREQ*DATA_W-1:0]   req_b,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [DATA_W-1:0]        res_data,
   output logic [$clog2(NREQ)-1:0]  res_id,
   output logic [CNT_W-1:0]         op_count
`ifdef ADDER_ARB_OVF_EN
   ,
   output logic                     res_ovf
`endif
);

   localparam int             IDW     = $clog2(NREQ);
   localparam logic [IDW:0]   NREQ_W  = NREQ[IDW:0];
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic [IDW-1:0]    rr_ptr_r;
   logic [IDW-1:0]    rr_next_s;
   logic [IDW-1:0]    grant_id_s;
   logic              any_valid_s;
   logic              accept_s;
   logic              xfer_s;
   logic              res_valid_s;
   logic [DATA_W-1:0] op_a_s;
   logic [DATA_W-1:0] op_b_s;
   logic [DATA_W-1:0] sum_s;
   logic [DATA_W-1:0] res_data_r;
   logic [IDW-1:0]    res_id_r;
   logic [CNT_W-1:0]  op_count_r;

   // First set bit of valid at or after ptr, wrapping modulo NREQ.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [IDW-1:0]  ptr);
      logic [2*NREQ-1:0] rot;
      logic [IDW:0]      off;
      logic [IDW:0]      idx;
      logic              found;
      rot   = {valid, valid} >> ptr;
      off   = {(IDW+1){1'b0}};
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && rot[k]) begin
            off   = k[IDW:0];
            found = 1'b1;
         end
      end
      idx = {1'b0, ptr} + off;
      if (idx >= NREQ_W) begin
         idx = idx - NREQ_W;
      end
      return idx[IDW-1:0];
   endfunction

   // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   // Next-state logic of the EMPTY/FULL result register.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_EMPTY: begin
            if (xfer_s) begin
               state_next_s = ST_FULL;
            end else begin
               state_next_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (xfer_s) begin
               state_next_s = ST_FULL;
            end else if (res_ready) begin
               state_next_s = ST_EMPTY;
            end else begin
               state_next_s = ST_FULL;
            end
         end
         default: state_next_s = ST_EMPTY;
      endcase
   end

   // FSM outputs: result valid and whether the register can take a new result this cycle.
   always_comb begin
      res_valid_s = 1'b0;
      accept_s    = 1'b1;
      case (state_r)
         ST_EMPTY: begin
            res_valid_s = 1'b0;
            accept_s    = 1'b1;
         end
         ST_FULL: begin
            res_valid_s = 1'b1;
            accept_s    = res_ready;
         end
         default: begin
            res_valid_s = 1'b0;
            accept_s    = 1'b1;
         end
      endcase
   end

   // Round-robin grant; suppressed during reset and while a held result blocks the register.
   always_comb begin
      any_valid_s = |req_valid;
      grant_id_s  = rr_pick(req_valid, rr_ptr_r);
      if (rst_n && accept_s && any_valid_s) begin
         req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_s;
      end else begin
         req_ready = {NREQ{1'b0}};
      end
   end

   assign xfer_s = |(req_valid & req_ready);

   // Operand select for the granted requester and the shared add.
   always_comb begin
      op_a_s = {DATA_W{1'b0}};
      op_b_s = {DATA_W{1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         op_a_s = op_a_s | (req_a[k*DATA_W +: DATA_W] & {DATA_W{grant_id_s == k[IDW-1:0]}});
         op_b_s = op_b_s | (req_b[k*DATA_W +: DATA_W] & {DATA_W{grant_id_s == k[IDW-1:0]}});
      end
      sum_s = op_a_s + op_b_s;
      if (grant_id_s == LAST_ID) begin
         rr_next_s = {IDW{1'b0}};
      end else begin
         rr_next_s = grant_id_s + IDW'(1);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Result, id, counter and pointer registers; all advance only on a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_data_r <= {DATA_W{1'b0}};
         res_id_r   <= {IDW{1'b0}};
         op_count_r <= {CNT_W{1'b0}};
         rr_ptr_r   <= {IDW{1'b0}};
      end else if (xfer_s) begin
         res_data_r <= sum_s;
         res_id_r   <= grant_id_s;
         op_count_r <= op_count_r + CNT_W'(1);
         rr_ptr_r   <= rr_next_s;
      end else begin
         res_data_r <= res_data_r;
         res_id_r   <= res_id_r;
         op_count_r <= op_count_r;
         rr_ptr_r   <= rr_ptr_r;
      end
   end

`ifdef ADDER_ARB_OVF_EN
   logic res_ovf_r;

   // Overflow flag travels with the sum it describes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_ovf_r <= 1'b0;
      end else if (xfer_s) begin
         res_ovf_r <= add_ovf(op_a_s[DATA_W-1], op_b_s[DATA_W-1], sum_s[DATA_W-1]);
      end else begin
         res_ovf_r <= res_ovf_r;
      end
   end

   assign res_ovf = res_ovf_r;
`endif

   assign res_valid = res_valid_s;
   assign res_data  = res_data_r;
   assign res_id    = res_id_r;
   assign op_count  = op_count_r;

endmodule
